load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/types_pkg.sv | 9 +
 rtl/lane_align.sv | 27 ++
 rtl/load_store_unit.sv | 91 +++++++++
 tb/tb_load_store_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// types_pkg: shared bus, access-size and LSU state types.
package types_pkg;
  typedef logic [31:0] DATA_BUS;
  typedef enum logic [1:0] {Byte, Half, Word} byte_format;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
  function automatic logic misaligned(byte_format fmt, logic [1:0] off);
    return (fmt == Half && off[0]) || (fmt == Word && off != 2'b00);
  endfunction
endpackage

// File: rtl/lane_align.sv
// lane_align: little-endian sub-word extract for loads and lane merge for stores.
module lane_align
  import types_pkg::*;
(
  input  DATA_BUS    word,
  input  logic [1:0] offset,
  input  byte_format fmt,
  input  logic       sign,
  input  DATA_BUS    wdata,
  output DATA_BUS    loadVal,
  output DATA_BUS    merged
);
  logic [4:0] bSh, hSh;
  logic [7:0] b;
  logic [15:0] h;
  DATA_BUS mask, ins;
  always_comb begin
    bSh = {offset, 3'b000};
    hSh = {offset[1], 4'b0000};
    b = 8'(word >> bSh);
    h = 16'(word >> hSh);
    loadVal = fmt == Byte ? {{24{sign & b[7]}}, b} : fmt == Half ? {{16{sign & h[15]}}, h} : word;
    mask = fmt == Byte ? 32'h0000_00ff << bSh : fmt == Half ? 32'h0000_ffff << hSh : 32'hffff_ffff;
    ins = fmt == Byte ? {24'b0, wdata[7:0]} << bSh : fmt == Half ? {16'b0, wdata[15:0]} << hSh : wdata;
    merged = (word & ~mask) | ins;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a single-port word RAM,
// sub-word stores done as read-modify-write.
module load_store_unit
  import types_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  byte_format req_fmt,
  input  logic       req_sign,
  input  DATA_BUS    req_addr,
  input  DATA_BUS    req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output DATA_BUS    rsp_rdata,
  output logic       rsp_err,
  output logic       mem_we,
  output DATA_BUS    mem_addr,
  output DATA_BUS    mem_wdata,
  input  DATA_BUS    mem_rdata
);
  localparam logic [2:0] LAT = 3'(RD_LATENCY);
  lsu_state_t state, nextState;
  logic weR, signR, accept, capture, mis;
  byte_format fmtR;
  logic [1:0] offR;
  logic [2:0] cnt;
  DATA_BUS wdataR, loadVal, merged;
  assign accept = state == IDLE && req_valid;
  assign capture = state == READ && cnt == LAT;
  assign mis = misaligned(req_fmt, req_addr[1:0]);
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign mem_we = state == WRITE;
  lane_align u_align (
    .word(mem_rdata),
    .offset(offR),
    .fmt(fmtR),
    .sign(signR),
    .wdata(wdataR),
    .loadVal(loadVal),
    .merged(merged)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (req_valid) nextState = mis ? RESP : (req_we && req_fmt == Word) ? WRITE : READ;
      READ: if (capture) nextState = weR ? WRITE : RESP;
      WRITE: nextState = RESP;
      RESP: if (rsp_ready) nextState = IDLE;
    endcase
  end
  // cnt restarts every time READ is entered; capture fires RD_LATENCY cycles after mem_addr goes valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      weR <= 1'b0;
      signR <= 1'b0;
      fmtR <= Byte;
      offR <= 2'b00;
      wdataR <= '0;
      cnt <= 3'd0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      cnt <= state == READ ? cnt + 3'd1 : 3'd0;
      if (accept) begin
        weR <= req_we;
        signR <= req_sign;
        fmtR <= req_fmt;
        offR <= req_addr[1:0];
        wdataR <= req_wdata;
        rsp_err <= mis;
        rsp_rdata <= '0;
        mem_wdata <= req_wdata;
        if (!mis) mem_addr <= {req_addr[31:2], 2'b00};
      end
      if (capture) begin
        if (weR) mem_wdata <= merged;
        else rsp_rdata <= loadVal;
      end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for two latency variants of the LSU.
module tb_load_store_unit;
  import types_pkg::*;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  logic clk = 0, rst_n = 0, sel = 0;
  logic reqValid = 0, reqWe = 0, reqSign = 0, rspReady = 0;
  byte_format reqFmt = Word;
  logic [31:0] reqAddr = 0, reqWdata = 0;
  logic rr1, rv1, re1, mw1, rr3, rv3, re3, mw3;
  logic [31:0] rd1, ma1, mwd1, mrd1, rd3, ma3, mwd3, mrd3, p0, p1;
  logic [31:0] ram1 [0:63];
  logic [31:0] ram3 [0:63];
  logic reqReady, rspValid, rspErr, memWe;
  logic [31:0] rspRdata, memAddr, memWdata;
  int vectors = 0, miscompares = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  assign reqReady = sel ? rr3 : rr1;
  assign rspValid = sel ? rv3 : rv1;
  assign rspErr = sel ? re3 : re1;
  assign memWe = sel ? mw3 : mw1;
  assign rspRdata = sel ? rd3 : rd1;
  assign memAddr = sel ? ma3 : ma1;
  assign memWdata = sel ? mwd3 : mwd1;
  load_store_unit #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid & !sel), .req_ready(rr1), .req_we(reqWe),
    .req_fmt(reqFmt), .req_sign(reqSign), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rv1), .rsp_ready(rspReady & !sel), .rsp_rdata(rd1), .rsp_err(re1),
    .mem_we(mw1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_rdata(mrd1)
  );
  load_store_unit #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid & sel), .req_ready(rr3), .req_we(reqWe),
    .req_fmt(reqFmt), .req_sign(reqSign), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rv3), .rsp_ready(rspReady & sel), .rsp_rdata(rd3), .rsp_err(re3),
    .mem_we(mw3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_rdata(mrd3)
  );
  // RAM models: read data valid RD_LATENCY cycles after the address
  always @(posedge clk) begin
    if (mw1) ram1[ma1[7:2]] <= mwd1;
    mrd1 <= ram1[ma1[7:2]];
    if (mw3) ram3[ma3[7:2]] <= mwd3;
    p0 <= ram3[ma3[7:2]];
    p1 <= p0;
    mrd3 <= p1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic doReq(input logic s, input logic we, input byte_format fmt, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int lat,
                       input logic [31:0] er, input logic ee, input int weCyc,
                       input logic [31:0] ewd, input int hold);
    exp_t e;
    int n, weN, weAt, busy;
    logic [31:0] weD;
    sb.push_back('{er, ee, lat});
    @(negedge clk);
    sel = s; reqValid = 1; reqWe = we; reqFmt = fmt; reqSign = sg; reqAddr = a; reqWdata = wd;
    n = 0; weN = 0; weAt = 0; busy = 0; weD = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        reqValid = 0; reqWe = ~we; reqFmt = Half; reqSign = ~sg;
        reqAddr = $urandom; reqWdata = $urandom;
        if (!ee) chk("mem_addr", memAddr, {a[31:2], 2'b00});
      end
      if (memWe) begin weN++; weAt = n; weD = memWdata; end
      if (reqReady) busy++;
    end while (!rspValid && n < 20);
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("rsp_rdata", rspRdata, e.rdata);
    chk("rsp_err", rspErr, e.err);
    chk("req_ready while busy", busy, 0);
    chk("write count", weN, weCyc != 0);
    if (weCyc != 0) begin
      chk("write cycle", weAt, weCyc);
      chk("mem_wdata", weD, ewd);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold rsp_valid", rspValid, 1);
      chk("hold rsp_rdata", rspRdata, e.rdata);
      chk("hold rsp_err", rspErr, e.err);
      chk("hold req_ready", reqReady, 0);
      chk("hold mem_we", memWe, 0);
    end
    rspReady = 1;
    @(negedge clk);
    rspReady = 0;
    chk("exit rsp_valid", rspValid, 0);
    chk("exit req_ready", reqReady, 1);
  endtask
  initial begin
    int bad;
    for (int i = 0; i < 64; i++) begin ram1[i] <= 0; ram3[i] <= 0; end
    ram1[4] <= 32'h8899AABB; ram1[8] <= 32'h11223344; ram3[8] <= 32'h11223344;
    repeat (2) @(negedge clk);
    chk("reset req_ready", rr1, 1);
    chk("reset rsp_valid", rv1, 0);
    chk("reset rsp_err", re1, 0);
    chk("reset rsp_rdata", rd1, 0);
    chk("reset mem_we", mw1, 0);
    chk("reset mem_addr", ma1, 0);
    chk("reset mem_wdata", mwd1, 0);
    rst_n = 1;
    doReq(0, 0, Byte, 1, 32'h12, 0, 3, 32'hFFFFFF99, 0, 0, 0, 0);
    doReq(0, 0, Byte, 0, 32'h12, 0, 3, 32'h00000099, 0, 0, 0, 0);
    doReq(0, 1, Byte, 0, 32'h11, 32'hFFFFFF5C, 4, 0, 0, 3, 32'h88995CBB, 0);
    doReq(0, 0, Word, 0, 32'h10, 0, 3, 32'h88995CBB, 0, 0, 0, 0);
    doReq(0, 0, Half, 0, 32'h13, 0, 1, 0, 1, 0, 0, 5);
    doReq(0, 0, Half, 1, 32'h12, 0, 3, 32'hFFFF8899, 0, 0, 0, 5);
    doReq(0, 1, Word, 0, 32'h20, 32'hCAFEF00D, 2, 0, 0, 1, 32'hCAFEF00D, 0);
    doReq(0, 1, Half, 0, 32'h22, 32'hABCD1234, 4, 0, 0, 3, 32'h1234F00D, 0);
    doReq(0, 0, Half, 1, 32'h20, 0, 3, 32'hFFFFF00D, 0, 0, 0, 0);
    doReq(0, 0, Byte, 0, 32'h23, 0, 3, 32'h00000012, 0, 0, 0, 0);
    doReq(0, 1, Word, 0, 32'h21, 32'h55555555, 1, 0, 1, 0, 0, 0);
    doReq(0, 1, Half, 0, 32'h11, 32'h55555555, 1, 0, 1, 0, 0, 0);
    doReq(0, 0, Byte, 1, 32'h13, 0, 3, 32'hFFFFFF88, 0, 0, 0, 0);
    // reset pulse while a half store is reading
    @(negedge clk);
    sel = 0; reqValid = 1; reqWe = 1; reqFmt = Half; reqSign = 0; reqAddr = 32'h10; reqWdata = 32'hDEAD;
    @(negedge clk);
    reqValid = 0;
    rst_n = 0;
    #1;
    chk("midreset req_ready", rr1, 1);
    chk("midreset rsp_valid", rv1, 0);
    chk("midreset rsp_err", re1, 0);
    chk("midreset rsp_rdata", rd1, 0);
    chk("midreset mem_we", mw1, 0);
    chk("midreset mem_addr", ma1, 0);
    chk("midreset mem_wdata", mwd1, 0);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv1 || mw1 || !rr1) bad++;
    end
    chk("post-reset idle", bad, 0);
    doReq(0, 0, Word, 0, 32'h10, 0, 3, 32'h88995CBB, 0, 0, 0, 0);
    doReq(1, 0, Word, 0, 32'h20, 0, 5, 32'h11223344, 0, 0, 0, 0);
    doReq(1, 1, Byte, 0, 32'h21, 32'h000000A5, 6, 0, 0, 5, 32'h1122A544, 0);
    doReq(1, 0, Word, 0, 32'h20, 0, 5, 32'h1122A544, 0, 0, 0, 2);
    doReq(1, 0, Byte, 1, 32'h21, 0, 5, 32'hFFFFFFA5, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
